// File: rtl/mem_bus_pkg.sv
// Shared definitions for the banked memory arbiter: per-master state encoding,
// bank-select bit position and default geometry.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } mst_state_t;

    localparam int unsigned BANK_SEL_BIT = 3;
    localparam int unsigned DEF_AW       = 14;
    localparam int unsigned DEF_DW       = 64;

endpackage

// File: rtl/mem_bank_rr.sv
// Two-way round-robin arbiter for one SRAM bank. The pointer names the master
// that wins the next conflict and flips to the loser only after a conflict.
module mem_bank_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Two-master (fetch, load/store) arbiter onto even/odd synchronous-read SRAM banks.
// Optional MEM_BANK_ADDR_CHECK_EN: out-of-range addresses answer with rsp_err, no bank access.
module mem_bank_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [63:0]     m0_addr,
    input  logic [DW-1:0]   m0_data_w,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_wen,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_data_r,
    output logic            m0_rsp_err,

    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [63:0]     m1_addr,
    input  logic [DW-1:0]   m1_data_w,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wen,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_data_r,
    output logic            m1_rsp_err,

    output logic            bE_en,
    output logic            bE_wen,
    output logic [AW-1:0]   bE_addr,
    output logic [DW-1:0]   bE_data_w,
    output logic [DW/8-1:0] bE_wstrb,
    input  logic [DW-1:0]   bE_data_r,

    output logic            bO_en,
    output logic            bO_wen,
    output logic [AW-1:0]   bO_addr,
    output logic [DW-1:0]   bO_data_w,
    output logic [DW/8-1:0] bO_wstrb,
    input  logic [DW-1:0]   bO_data_r
);

    localparam int unsigned SW = DW / 8;

    logic [1:0]    req_valid, rsp_ready, wen, req_ready;
    logic [63:0]   addr   [2];
    logic [DW-1:0] data_w [2];
    logic [SW-1:0] wstrb  [2];

    mst_state_t    state    [2];
    mst_state_t    state_nx [2];
    logic [1:0]    eligible, bank_sel, addr_bad, req_e, req_o, gnt_e, gnt_o;
    logic [1:0]    acc_bank, acc_wen, acc_err, rsp_err;
    logic [DW-1:0] rsp_data [2];
    logic          unused_addr;

    assign req_valid = {m1_req_valid, m0_req_valid};
    assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};
    assign wen       = {m1_wen, m0_wen};
    assign addr[0]   = m0_addr;
    assign addr[1]   = m1_addr;
    assign data_w[0] = m0_data_w;
    assign data_w[1] = m1_data_w;
    assign wstrb[0]  = m0_wstrb;
    assign wstrb[1]  = m1_wstrb;

`ifdef MEM_BANK_ADDR_CHECK_EN
    assign unused_addr = ^{addr[0][2:0], addr[1][2:0]};
`else
    assign unused_addr = ^{addr[0][63:AW+4], addr[0][2:0], addr[1][63:AW+4], addr[1][2:0]};
`endif

    // Eligibility is gated by reset so no grant or bank strobe leaks out while RST is high.
    always_comb begin
        eligible = '0;
        bank_sel = '0;
        addr_bad = '0;
        req_e    = '0;
        req_o    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            eligible[i] = !RST && req_valid[i] &&
                          (state[i] == ST_IDLE || (state[i] == ST_RESP && rsp_ready[i]));
            bank_sel[i] = addr[i][BANK_SEL_BIT];
`ifdef MEM_BANK_ADDR_CHECK_EN
            addr_bad[i] = |addr[i][63:AW+4];
`else
            addr_bad[i] = 1'b0;
`endif
            req_e[i] = eligible[i] && !addr_bad[i] && !bank_sel[i];
            req_o[i] = eligible[i] && !addr_bad[i] &&  bank_sel[i];
        end
    end

    mem_bank_rr u_rr_even (.clk(CLK), .rst(RST), .req(req_e), .gnt(gnt_e));
    mem_bank_rr u_rr_odd  (.clk(CLK), .rst(RST), .req(req_o), .gnt(gnt_o));

    // Out-of-range requests take no bank slot, so they are granted unconditionally.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            req_ready[i] = eligible[i] && (addr_bad[i] || gnt_e[i] || gnt_o[i]);
            state_nx[i]  = state[i];
            case (state[i])
                ST_IDLE: if (req_ready[i]) state_nx[i] = ST_ACC;
                ST_ACC:  state_nx[i] = ST_RESP;
                ST_RESP: if (rsp_ready[i]) state_nx[i] = req_ready[i] ? ST_ACC : ST_IDLE;
                default: state_nx[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bE_en     = |gnt_e;
        bE_wen    = 1'b0;
        bE_addr   = '0;
        bE_data_w = '0;
        bE_wstrb  = '0;
        bO_en     = |gnt_o;
        bO_wen    = 1'b0;
        bO_addr   = '0;
        bO_data_w = '0;
        bO_wstrb  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (gnt_e[i]) begin
                bE_wen    = wen[i];
                bE_addr   = addr[i][AW+3:4];
                bE_data_w = data_w[i];
                bE_wstrb  = wstrb[i];
            end
            if (gnt_o[i]) begin
                bO_wen    = wen[i];
                bO_addr   = addr[i][AW+3:4];
                bO_data_w = data_w[i];
                bO_wstrb  = wstrb[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i]    <= ST_IDLE;
                acc_bank[i] <= 1'b0;
                acc_wen[i]  <= 1'b0;
                acc_err[i]  <= 1'b0;
                rsp_err[i]  <= 1'b0;
                rsp_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= state_nx[i];
                if (req_ready[i]) begin
                    acc_bank[i] <= bank_sel[i];
                    acc_wen[i]  <= wen[i];
                    acc_err[i]  <= addr_bad[i];
                end
                if (state[i] == ST_ACC) begin
                    rsp_err[i] <= acc_err[i];
                    if (acc_wen[i] || acc_err[i]) begin
                        rsp_data[i] <= '0;
                    end else begin
                        rsp_data[i] <= acc_bank[i] ? bO_data_r : bE_data_r;
                    end
                end
            end
        end
    end

    assign m0_req_ready = req_ready[0];
    assign m1_req_ready = req_ready[1];
    assign m0_rsp_valid = (state[0] == ST_RESP);
    assign m1_rsp_valid = (state[1] == ST_RESP);
    assign m0_data_r    = rsp_data[0];
    assign m1_data_r    = rsp_data[1];
    assign m0_rsp_err   = rsp_err[0];
    assign m1_rsp_err   = rsp_err[1];

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Self-checking bench for mem_bank_arbiter: transaction-level model of arbitration,
// latency and bank contents, compared every cycle, plus directed literal checks.
module tb_mem_bank_arbiter;

    localparam int AW = 14;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int NW = 1 << AW;

    typedef struct {
        logic [63:0]   a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          w;
    } req_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [1:0]    rv = '0, rr = 2'b11, rdy, rsv, wm = '0, em;
    logic [63:0]   ad [2];
    logic [DW-1:0] wd [2];
    logic [SW-1:0] st [2];
    logic [DW-1:0] rd [2];

    logic          bE_en, bE_wen, bO_en, bO_wen;
    logic [AW-1:0] bE_addr, bO_addr;
    logic [DW-1:0] bE_data_w, bO_data_w;
    logic [SW-1:0] bE_wstrb, bO_wstrb;
    logic [DW-1:0] bE_data_r = '0, bO_data_r = '0;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mem_bank_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req_valid(rv[0]), .m0_req_ready(rdy[0]), .m0_addr(ad[0]), .m0_data_w(wd[0]),
        .m0_wstrb(st[0]), .m0_wen(wm[0]), .m0_rsp_valid(rsv[0]), .m0_rsp_ready(rr[0]),
        .m0_data_r(rd[0]), .m0_rsp_err(em[0]),
        .m1_req_valid(rv[1]), .m1_req_ready(rdy[1]), .m1_addr(ad[1]), .m1_data_w(wd[1]),
        .m1_wstrb(st[1]), .m1_wen(wm[1]), .m1_rsp_valid(rsv[1]), .m1_rsp_ready(rr[1]),
        .m1_data_r(rd[1]), .m1_rsp_err(em[1]),
        .bE_en(bE_en), .bE_wen(bE_wen), .bE_addr(bE_addr), .bE_data_w(bE_data_w),
        .bE_wstrb(bE_wstrb), .bE_data_r(bE_data_r),
        .bO_en(bO_en), .bO_wen(bO_wen), .bO_addr(bO_addr), .bO_data_w(bO_data_w),
        .bO_wstrb(bO_wstrb), .bO_data_r(bO_data_r)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural SRAM banks (synchronous read, byte-strobed write).
    logic [DW-1:0] sram [2][NW];
    always @(posedge CLK) begin
        if (bE_en && bE_wen)  sram[0][bE_addr] <= merge(sram[0][bE_addr], bE_data_w, bE_wstrb);
        if (bE_en && !bE_wen) bE_data_r <= sram[0][bE_addr];
        if (bO_en && bO_wen)  sram[1][bO_addr] <= merge(sram[1][bO_addr], bO_data_w, bO_wstrb);
        if (bO_en && !bO_wen) bO_data_r <= sram[1][bO_addr];
    end

    // Model state: phase per master (0 idle, 1 bank access, 2 response), per-bank priority.
    logic [DW-1:0] mm [2][NW];
    int            ph [2] = '{0, 0};
    int            n_ph [2] = '{0, 0};
    int            ptr [2] = '{0, 0};
    int            n_ptr [2] = '{0, 0};
    logic [DW-1:0] ed [2] = '{'0, '0};
    logic [DW-1:0] n_ed [2] = '{'0, '0};
    logic          ee [2] = '{1'b0, 1'b0};
    logic          n_ee [2] = '{1'b0, 1'b0};
    int            win [2];
    logic [1:0]    el, bk, bad, er, acc = '0;
    logic [AW-1:0] idx [2];
    logic          c0, c1, exp_en;

    int            glog[$];
    logic [DW-1:0] got_d0[$], got_d1[$];
    logic          got_e0[$];
    int            cnt_e = 0, dual = 0;

    always @(negedge CLK) begin
        for (int m = 0; m < 2; m++) begin
            el[m]  = !RST && rv[m] && (ph[m] == 0 || (ph[m] == 2 && rr[m]));
            bk[m]  = ad[m][3];
            idx[m] = ad[m][AW+3:4];
`ifdef MEM_BANK_ADDR_CHECK_EN
            bad[m] = (ad[m][63:AW+4] != '0);
`else
            bad[m] = 1'b0;
`endif
        end
        n_ptr = ptr;
        for (int b = 0; b < 2; b++) begin
            c0 = el[0] && !bad[0] && (int'(bk[0]) == b);
            c1 = el[1] && !bad[1] && (int'(bk[1]) == b);
            if (c0 && c1) begin
                win[b]   = ptr[b];
                n_ptr[b] = 1 - ptr[b];
            end else if (c0) win[b] = 0;
            else if (c1)     win[b] = 1;
            else             win[b] = -1;
        end
        for (int m = 0; m < 2; m++) er[m] = el[m] && (bad[m] || win[bk[m]] == m);

        for (int m = 0; m < 2; m++) begin
            chk("req_ready", {63'd0, rdy[m]}, {63'd0, er[m]});
            chk("rsp_valid", {63'd0, rsv[m]}, {63'd0, !RST && ph[m] == 2});
            if (RST || ph[m] == 2) begin
                chk("data_r", rd[m], RST ? '0 : ed[m]);
                chk("rsp_err", {63'd0, em[m]}, {63'd0, RST ? 1'b0 : ee[m]});
            end
        end
        exp_en = win[0] >= 0;
        chk("bE_en", {63'd0, bE_en}, {63'd0, exp_en});
        chk("bE_addr", {50'd0, bE_addr}, exp_en ? {50'd0, idx[win[0]]} : '0);
        chk("bE_wen", {63'd0, bE_wen}, exp_en ? {63'd0, wm[win[0]]} : '0);
        chk("bE_data_w", bE_data_w, exp_en ? wd[win[0]] : '0);
        chk("bE_wstrb", {56'd0, bE_wstrb}, exp_en ? {56'd0, st[win[0]]} : '0);
        exp_en = win[1] >= 0;
        chk("bO_en", {63'd0, bO_en}, {63'd0, exp_en});
        chk("bO_addr", {50'd0, bO_addr}, exp_en ? {50'd0, idx[win[1]]} : '0);
        chk("bO_wen", {63'd0, bO_wen}, exp_en ? {63'd0, wm[win[1]]} : '0);
        chk("bO_data_w", bO_data_w, exp_en ? wd[win[1]] : '0);
        chk("bO_wstrb", {56'd0, bO_wstrb}, exp_en ? {56'd0, st[win[1]]} : '0);

        if (RST) begin
            n_ph  = '{0, 0};
            n_ptr = '{0, 0};
            n_ed  = '{'0, '0};
            n_ee  = '{1'b0, 1'b0};
        end else begin
            for (int m = 0; m < 2; m++) begin
                n_ed[m] = ed[m];
                n_ee[m] = ee[m];
                if (er[m]) begin
                    n_ph[m] = 1;
                    n_ee[m] = bad[m];
                    if (bad[m]) n_ed[m] = '0;
                    else if (wm[m]) begin
                        mm[bk[m]][idx[m]] = merge(mm[bk[m]][idx[m]], wd[m], st[m]);
                        n_ed[m] = '0;
                    end else n_ed[m] = mm[bk[m]][idx[m]];
                    if (!bad[m] && bk[m] == 1'b0) glog.push_back(m);
                end else if (ph[m] == 1)        n_ph[m] = 2;
                else if (ph[m] == 2 && rr[m])   n_ph[m] = 0;
                else                            n_ph[m] = ph[m];
            end
        end

        acc = rv & rdy & {2{!RST}};
        if (!RST && rsv[0] && rr[0]) begin got_d0.push_back(rd[0]); got_e0.push_back(em[0]); end
        if (!RST && rsv[1] && rr[1]) got_d1.push_back(rd[1]);
        if (bE_en) cnt_e++;
        if (bE_en && bO_en) dual++;
    end

    always @(posedge CLK) begin
        ph  <= n_ph;
        ptr <= n_ptr;
        ed  <= n_ed;
        ee  <= n_ee;
    end

    // Master drivers: hold each request until accepted, then present the next.
    req_t q0[$], q1[$];
    always @(posedge CLK) begin
        req_t r;
        #1;
        if (rv[0] && acc[0]) rv[0] = 1'b0;
        if (!rv[0] && q0.size() > 0) begin
            r = q0.pop_front();
            ad[0] = r.a; wd[0] = r.d; st[0] = r.s; wm[0] = r.w; rv[0] = 1'b1;
        end
        if (rv[1] && acc[1]) rv[1] = 1'b0;
        if (!rv[1] && q1.size() > 0) begin
            r = q1.pop_front();
            ad[1] = r.a; wd[1] = r.d; st[1] = r.s; wm[1] = r.w; rv[1] = 1'b1;
        end
    end

    task automatic push(input int m, input logic [63:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic w);
        req_t r;
        r.a = a; r.d = d; r.s = s; r.w = w;
        if (m == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && rv == 2'b00 && ph[0] == 0 && ph[1] == 0)
               && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got busy expected idle", tag);
        end
    endtask

    initial begin
        int n, e0, r0;
        ad = '{64'd0, 64'd0};
        wd = '{'0, '0};
        st = '{'0, '0};
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NW; i++) begin
                sram[b][i] = '0;
                mm[b][i]   = '0;
            end

        // Write queued during reset: must not be accepted until RST falls.
        push(0, 64'h10, 64'hDEAD_BEEF, 8'hFF, 1'b1);
        push(0, 64'h10, 64'h0, 8'h00, 1'b0);
        repeat (3) step();
        chk("reset_ready_m0", {63'd0, rdy[0]}, 64'd0);
        chk("reset_bE_en", {63'd0, bE_en}, 64'd0);
        RST = 1'b0;
        wait_idle("write_read");
        chk("wr_rd_count", got_d0.size(), 2);
        chk("wr_rd_data", got_d0[got_d0.size()-1], 64'hDEAD_BEEF);
        chk("wr_rd_bE_en_count", cnt_e, 2);

        push(0, 64'h10, 64'h1111_2222_3333_4444, 8'h0F, 1'b1);
        push(0, 64'h10, 64'h0, 8'h00, 1'b0);
        wait_idle("partial_strobe");
        chk("partial_strobe", got_d0[got_d0.size()-1], 64'h0000_0000_3333_4444);

        push(0, 64'h00, 64'h0, 8'h00, 1'b0);
        push(1, 64'h08, 64'h0, 8'h00, 1'b0);
        wait_idle("dual_bank");
        chk("dual_bank_same_cycle", dual, 1);
        push(1, 64'h18, 64'hCAFE, 8'hFF, 1'b1);
        push(1, 64'h18, 64'h0, 8'h00, 1'b0);
        wait_idle("odd_bank");
        chk("odd_bank_read", got_d1[got_d1.size()-1], 64'hCAFE);

        glog.delete();
        for (int k = 0; k < 3; k++) begin
            push(0, 64'h20, 64'h0, 8'h00, 1'b0);
            push(1, 64'h20, 64'h0, 8'h00, 1'b0);
        end
        wait_idle("conflict");
        chk("grant_count", glog.size(), 6);
        for (int k = 0; k < 6; k++)
            chk("grant_order", (glog.size() > k) ? glog[k] : 99, k % 2);

        push(0, 64'h40, 64'hAAAA, 8'hFF, 1'b1);
        wait_idle("pre_hold");
        rr[1] = 1'b0;
        push(1, 64'h40, 64'h0, 8'h00, 1'b0);
        push(1, 64'h48, 64'h0, 8'h00, 1'b0);
        n = 0;
        while (!rsv[1] && n < 50) begin step(); n++; end
        chk("hold_rsp_seen", {63'd0, rsv[1]}, 64'd1);
        push(0, 64'h40, 64'hBBBB, 8'hFF, 1'b1);
        repeat (5) step();
        chk("hold_data", rd[1], 64'hAAAA);
        chk("hold_valid", {63'd0, rsv[1]}, 64'd1);
        chk("hold_next_pending", {63'd0, rv[1]}, 64'd1);
        chk("hold_next_ready", {63'd0, rdy[1]}, 64'd0);
        rr[1] = 1'b1;
        wait_idle("hold");
        chk("hold_second_rsp", got_d1[got_d1.size()-1], 64'h0);
        chk("hold_first_rsp", got_d1[got_d1.size()-2], 64'hAAAA);
        push(0, 64'h40, 64'h0, 8'h00, 1'b0);
        wait_idle("after_hold");
        chk("after_hold_read", got_d0[got_d0.size()-1], 64'hBBBB);

        e0 = cnt_e;
        push(0, 64'h1_0000_0000, 64'h0, 8'h00, 1'b0);
        wait_idle("high_addr");
`ifdef MEM_BANK_ADDR_CHECK_EN
        chk("high_addr_err", {63'd0, got_e0[got_e0.size()-1]}, 64'd1);
        chk("high_addr_no_bank", cnt_e - e0, 0);
`else
        chk("high_addr_err", {63'd0, got_e0[got_e0.size()-1]}, 64'd0);
        chk("high_addr_alias_bank", cnt_e - e0, 1);
`endif
        chk("high_addr_data", got_d0[got_d0.size()-1], 64'h0);

        // Even-bank pointer now favours m1; a reset must return it to m0.
        push(0, 64'h20, 64'h5555, 8'hFF, 1'b1);
        wait_idle("pre_reset");
        r0 = got_d0.size();
        push(0, 64'h20, 64'h0, 8'h00, 1'b0);
        n = 0;
        while (ph[0] != 1 && n < 50) begin step(); n++; end
        chk("reset_reached_acc", ph[0], 1);
        RST = 1'b1;
        step();
        chk("reset_rsp_valid", {62'd0, rsv}, 64'd0);
        step();
        RST = 1'b0;
        repeat (4) step();
        chk("reset_discard", got_d0.size(), r0);
        glog.delete();
        push(0, 64'h20, 64'h0, 8'h00, 1'b0);
        push(1, 64'h20, 64'h0, 8'h00, 1'b0);
        wait_idle("post_reset");
        chk("post_reset_first_grant", (glog.size() > 0) ? glog[0] : 99, 0);
        chk("post_reset_second_grant", (glog.size() > 1) ? glog[1] : 99, 1);
        chk("post_reset_m0_data", got_d0[got_d0.size()-1], 64'h5555);
        chk("post_reset_m1_data", got_d1[got_d1.size()-1], 64'h5555);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bank_arbiter.md
MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 Parameter AW, default 14: per-bank SRAM word-address width.
REQ-002 Parameter DW, default 64: data width; byte strobes are DW/8 bits.
REQ-003 Port CLK, input, 1: single clock; all state on rising edge.
REQ-004 Port RST, input, 1: reset, asynchronous and active-high.
REQ-005 Ports mN_req_valid / mN_req_ready (N=0,1), input/output, 1: request handshake; master 0 = fetch, master 1 = load/store.
REQ-006 Ports mN_addr, input, 64: byte address. mN_data_w, input, DW: write data. mN_wstrb, input, DW/8: byte enables. mN_wen, input, 1: 1 = write.
REQ-007 Ports mN_rsp_valid / mN_rsp_ready, output/input, 1: response handshake.
REQ-008 Ports mN_data_r, output, DW: read data (0 for writes). mN_rsp_err, output, 1: access error.
REQ-009 Ports bE_/bO_ en, wen, output, 1: even/odd bank access strobe and write enable.
REQ-010 Ports bE_/bO_ addr, output, AW; data_w, output, DW; wstrb, output, DW/8; data_r, input, DW: synchronous-read bank interface.

Function
REQ-011 Bank select SHALL be addr[3] (0 = even, 1 = odd); bank word index SHALL be addr[AW+3:4]; addr[2:0] ignored.
REQ-012 Each master SHALL have a state machine IDLE -> ACC -> RESP -> IDLE|ACC.
REQ-013 Master is eligible when req_valid=1 and state is IDLE, or state is RESP with rsp_ready=1.
REQ-014 Per bank, one eligible requester SHALL be granted; two eligible masters targeting different banks SHALL both be granted in the same cycle.
REQ-015 On same-bank conflict, grant goes to that bank's priority pointer; pointer flips to the loser only after a conflict grant; non-conflict grants leave it unchanged.
REQ-016 req_ready SHALL equal eligible AND granted (combinational); acceptance = req_valid & req_ready.
REQ-017 In the accept cycle, the granted bank's en=1 and addr/data_w/wstrb/wen SHALL be driven from the winner; otherwise en=0, other bank outputs 0.
REQ-018 Accept at edge T -> state ACC; in ACC, bank data_r SHALL be captured into the response register (writes capture 0); state -> RESP.
REQ-019 rsp_valid SHALL be 1 exactly in RESP; data_r/rsp_err SHALL be stable until rsp_valid & rsp_ready; fixed latency 2 cycles accept-to-rsp_valid.
REQ-020 In RESP with rsp_ready=1 and a new grant, the next request SHALL be accepted in the same cycle (back-to-back, one response per 2 cycles minimum); no grant -> IDLE.
REQ-021 At most one outstanding request per master; ordering per master preserved.
REQ-022 Master in ACC SHALL not be re-granted; a denied requester sees req_ready=0 and SHALL hold its request.

Reset
REQ-023 While RST=1: all states IDLE, rsp_valid=0, data_r=0, rsp_err=0, both priority pointers = master 0, all req_ready=0, all bank en=0.
REQ-024 Reset mid-transaction SHALL discard in-flight requests without a response; first grant is possible the cycle after RST falls.

Configuration
REQ-025 Macro MEM_BANK_ADDR_CHECK_EN defined: request with addr[63:AW+4] != 0 SHALL be accepted without bank access (en=0), then respond at the same latency with rsp_err=1, data_r=0.
REQ-026 Macro undefined: high address bits ignored (aliasing); rsp_err tied 0.

Structure
REQ-027 Shared package mem_bus_pkg SHALL hold the state encoding (IDLE/ACC/RESP), the bank-select bit index (3), and default AW/DW.
REQ-028 Sub-module mem_bank_rr (2-way round-robin arbiter with pointer) SHALL be instantiated once per bank.

Verification
REQ-029 m0 write 0x0000_0010 data 0xDEAD_BEEF strb 0xFF, then m0 read -> bE_en once per request; rsp at +2 cycles returns 0xDEAD_BEEF.
REQ-030 m0 addr 0x00, m1 addr 0x08, same cycle -> both req_ready=1; bE_en and bO_en both 1; both rsp_valid two cycles later.
REQ-031 m0 and m1 both addr 0x20 for 3 requests each -> grants m0, m1, m0, m1, m0, m1.
REQ-032 m1 read, rsp_ready=0 for 5 cycles while m0 writes the same bank -> m1_data_r holds; no new m1 accept until rsp_ready.
REQ-033 MEM_BANK_ADDR_CHECK_EN, m0 addr 0x1_0000_0000 -> no bank en; rsp_err=1, data_r=0 at +2.
REQ-034 RST pulsed during ACC -> rsp_valid=0, pointers = m0; fresh request completes normally.
